// File: rtl/mips_mem_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, data memory geometry
// and the request legality check.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    localparam int MEM_DEPTH = 32;
    localparam int MEM_IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } lsu_state_e;

    // Anything beyond the 32-word window, a misaligned access or the reserved size is an error.
    function automatic logic lsu_req_error(input logic [1:0] size, input logic [31:0] addr);
        logic bad;
        bad = (addr[31:MEM_IDX_W+2] != '0);
        case (size)
            SZ_BYTE: bad = bad;
            SZ_HALF: bad = bad | addr[0];
            SZ_WORD: bad = bad | (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Little-endian lane handling: extracts and extends a load lane, and merges a store lane
// into a previously read word.
module lsu_byte_lane
    import mips_mem_pkg::*;
#(
    parameter int REGSIZE = 32
) (
    input  logic [REGSIZE-1:0] word_i,
    input  logic [REGSIZE-1:0] wdata_i,
    input  logic [1:0]         size_i,
    input  logic               signed_i,
    input  logic [1:0]         lane_i,
    output logic [REGSIZE-1:0] load_o,
    output logic [REGSIZE-1:0] store_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Word accesses pass straight through; sub-word accesses touch only the addressed lane.
    always_comb begin
        byte_sel = word_i[{lane_i, 3'b000} +: 8];
        half_sel = word_i[{lane_i[1], 4'b0000} +: 16];
        load_o   = word_i;
        store_o  = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_o  = {{(REGSIZE-8){signed_i & byte_sel[7]}}, byte_sel};
                store_o = word_i;
                store_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                load_o  = {{(REGSIZE-16){signed_i & half_sel[15]}}, half_sel};
                store_o = word_i;
                store_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: begin
                load_o  = word_i;
                store_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the pipeline and a 32-word data memory; sub-word stores are
// done as read-modify-write. All outputs are registered from the next-state decode.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int REGSIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [31:0]          req_addr,
    input  logic [REGSIZE-1:0]   req_wdata,
    output logic                 resp_valid,
    output logic [REGSIZE-1:0]   resp_rdata,
    output logic                 resp_error,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [MEM_IDX_W-1:0] mem_addr,
    output logic [REGSIZE-1:0]   mem_wdata,
    input  logic [REGSIZE-1:0]   mem_rdata
);

    lsu_state_e           state_q, state_d;
    logic                 write_q, write_d;
    logic [1:0]           size_q, size_d;
    logic                 sgn_q, sgn_d;
    logic [31:0]          addr_q, addr_d;
    logic [REGSIZE-1:0]   wdata_q, wdata_d;
    logic [REGSIZE-1:0]   data_q, data_d;

    logic                 req_ready_q, req_ready_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [REGSIZE-1:0]   resp_rdata_q, resp_rdata_d;
    logic                 resp_error_q, resp_error_d;
    logic                 mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;
    logic [MEM_IDX_W-1:0] mem_addr_q, mem_addr_d;
    logic [REGSIZE-1:0]   mem_wdata_q, mem_wdata_d;

    logic                 req_err;
    logic [REGSIZE-1:0]   lane_load;
    logic [REGSIZE-1:0]   lane_store;

    // The lane logic sees next-cycle request fields and word so outputs can be registered.
    lsu_byte_lane #(
        .REGSIZE (REGSIZE)
    ) u_lane (
        .word_i   (data_d),
        .wdata_i  (wdata_d),
        .size_i   (size_d),
        .signed_i (sgn_d),
        .lane_i   (addr_d[1:0]),
        .load_o   (lane_load),
        .store_o  (lane_store)
    );

    assign req_err = lsu_req_error(size_d, addr_d);

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        sgn_d        = sgn_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        data_d       = data_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    size_d  = req_size;
                    sgn_d   = req_signed;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (lsu_req_error(req_size, req_addr)) begin
                        state_d = RESP;
                    end else if (req_write && req_size == SZ_WORD) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                data_d  = mem_rdata;
                state_d = write_q ? WR : RESP;
            end
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode for the state being entered; every output is low unless its state selects it.
    always_comb begin
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_error_d = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;

        case (state_d)
            IDLE: req_ready_d = 1'b1;
            RD: begin
                mem_read_d = 1'b1;
                mem_addr_d = addr_d[MEM_IDX_W+1:2];
            end
            WR: begin
                mem_write_d = 1'b1;
                mem_addr_d  = addr_d[MEM_IDX_W+1:2];
                mem_wdata_d = lane_store;
            end
            RESP: begin
                resp_valid_d = 1'b1;
                resp_error_d = req_err;
                resp_rdata_d = (req_err || write_d) ? '0 : lane_load;
            end
            default: req_ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            size_q       <= '0;
            sgn_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            data_q       <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            sgn_q        <= sgn_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            data_q       <= data_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter REGSIZE, default 32: data word width.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  1: pipeline presents a memory request.
REQ-005 SHALL have port req_ready  output  1: unit accepts a request this cycle.
REQ-006 SHALL have port req_write  input  1: 1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-008 SHALL have port req_signed  input  1: loads only; 1 = sign-extend, 0 = zero-extend.
REQ-009 SHALL have port req_addr  input  32: byte address.
REQ-010 SHALL have port req_wdata  input  REGSIZE: store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1: one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  REGSIZE: extended load result; 0 for stores and errors.
REQ-013 SHALL have port resp_error  output  1: qualified by resp_valid; misaligned, out-of-range or illegal size.
REQ-014 SHALL have ports mem_read  output  1, mem_write  output  1, mem_addr  output  5 (word index), mem_wdata  output  REGSIZE: drive the word-addressed data memory.
REQ-015 SHALL have port mem_rdata  input  REGSIZE: memory returns this combinationally in the same cycle mem_read is high.

Function
REQ-016 SHALL implement states IDLE, RD, WR, RESP; req_ready = 1 only in IDLE.
REQ-017 SHALL latch write, size, signed, addr and wdata on the cycle where req_valid && req_ready.
REQ-018 SHALL flag an error when req_size = 11, when halfword addr[0] != 0, when word addr[1:0] != 0, or when addr[31:7] != 0.
REQ-019 SHALL, on an erroring request, go IDLE -> RESP with no mem_read or mem_write pulse.
REQ-020 SHALL handle a load as IDLE -> RD -> RESP; in RD, mem_read = 1 and mem_addr = addr[6:2]; mem_rdata is captured at the end of RD.
REQ-021 SHALL extract byte lane addr[1:0] or halfword lane addr[1] little-endian, then sign- or zero-extend per req_signed.
REQ-022 SHALL handle a word store as IDLE -> WR -> RESP; in WR, mem_write = 1 and mem_wdata = wdata.
REQ-023 SHALL handle a byte or halfword store as read-modify-write, IDLE -> RD -> WR -> RESP; WR writes the captured word with only the addressed lane replaced by wdata[7:0] or wdata[15:0].
REQ-024 SHALL assert resp_valid for exactly one cycle, in RESP, then return to IDLE. Latency from the accept edge: error 1 cycle; load or word store 2 cycles; sub-word store 3 cycles.
REQ-025 SHALL have no response backpressure; a new request may be accepted in the IDLE cycle directly after RESP.
REQ-026 SHALL hold mem_read and mem_write at 0 outside RD and WR, and never assert both together.
REQ-027 SHALL hold mem_addr and mem_wdata at 0 when neither strobe is high.
REQ-028 SHALL pass an all-x mem_rdata word through to resp_rdata unmodified in the extracted lane, with no error raised.

Reset
REQ-029 SHALL, while rst_n = 0 at a clock edge, enter IDLE and clear all latched request fields and captured data.
REQ-030 SHALL drive all outputs to 0 during reset, except req_ready, which reads 1 in the first cycle after reset release.
REQ-031 SHALL, when reset lands in RD, WR or RESP, abandon the transaction: no mem_write in the cycle after reset and no resp_valid.

Structure
REQ-032 SHALL place the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the state encoding and the memory depth constant (32 words, 5-bit index) in shared package mips_mem_pkg.
REQ-033 SHALL implement lane extract/extend and lane merge in one combinational sub-module, lsu_byte_lane; the FSM and the request/data registers stay in load_store_unit.

Verification
REQ-034 SHALL cover word store then load: store addr 0x10, data 0xDEADBEEF -> mem_write for 1 cycle at mem_addr 4, resp 2 cycles later; then load word 0x10 -> resp_rdata 0xDEADBEEF, resp_error 0.
REQ-035 SHALL cover byte store read-modify-write: word 4 holds 0xDEADBEEF; store byte addr 0x11, data 0x55 -> RD then WR with mem_wdata 0xDEAD55EF; resp_valid 3 cycles after accept.
REQ-036 SHALL cover load extension: word 4 = 0xDEAD80EF; lb 0x11 -> 0xFFFFFF80; lbu 0x11 -> 0x00000080; lh 0x12 -> 0xFFFFDEAD.
REQ-037 SHALL cover errors: lw 0x13, lh 0x11, sw 0x80 and size 11 -> resp_error 1 after 1 cycle, no memory strobes, resp_rdata 0.
REQ-038 SHALL cover back-to-back traffic: req_valid held high across 3 requests -> req_ready low during RD/WR/RESP and each request accepted in the first IDLE cycle after its predecessor's RESP.
REQ-039 SHALL cover reset mid-operation: rst_n = 0 during RD of a sub-word store -> no mem_write, no resp_valid, req_ready = 1 in the first cycle after reset release.
